// File: rtl/control_sequencer.sv
// control_sequencer
//   Multi-cycle control FSM for the RISC core. Every instruction walks
//   FETCH -> DECODE -> EXEC -> (MEM) -> (WB) and retires on the cycle the
//   FSM heads back to FETCH. HALT and ERROR are terminal until reset.
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-low reset
//   start             leave IDLE and begin fetching
//   opcode[7:0]       decoder opcode, [7:4] class, [3:0] function
//   imem_valid        instruction word valid (waited on in FETCH)
//   dmem_ready        data access complete (waited on in MEM)
//   alu_zero/sign/carry  ALU flags, captured in EXEC of ALU instructions
//   imem_req, ir_load            fetch request / instruction register load
//   alu_op, alu_src_imm          ALU function and B-operand select
//   dmem_req, dmem_we            data memory request / write enable
//   reg_write, wb_sel_mem        register write / writeback source (1=mem)
//   pc_write, pc_src             PC strobe, 0=PC+4 1=label 2=rsVal
//   halted, illegal, bus_error   sticky stop causes
//   state                        current FSM state (debug)
//   instr_count                  retired instruction count (wraps)
module control_sequencer #(
   parameter int TIMEOUT = 16,
   parameter int COUNT_W = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [7:0]         opcode,
   input  logic               imem_valid,
   input  logic               dmem_ready,
   input  logic               alu_zero,
   input  logic               alu_sign,
   input  logic               alu_carry,
   output logic               imem_req,
   output logic               ir_load,
   output logic [3:0]         alu_op,
   output logic               alu_src_imm,
   output logic               dmem_req,
   output logic               dmem_we,
   output logic               reg_write,
   output logic               wb_sel_mem,
   output logic               pc_write,
   output logic [1:0]         pc_src,
   output logic               halted,
   output logic               illegal,
   output logic               bus_error,
   output logic [2:0]         state,
   output logic [COUNT_W-1:0] instr_count
);

   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6,
      S_ERROR  = 3'd7
   } state_t;

   state_t             state_q, state_d;
   logic [7:0]         op_q, op_d;
   logic [2:0]         flags_q, flags_d;      // {carry, sign, zero}
   logic [TW-1:0]      timer_q, timer_d;
   logic [COUNT_W-1:0] cnt_q, cnt_d;
   logic               halted_q, halted_d;
   logic               illegal_q, illegal_d;
   logic               bus_error_q, bus_error_d;
   logic               retire;

   function automatic logic is_legal(input logic [7:0] op);
      case (op[7:4])
         4'd0, 4'd1:             return op[3:0] <= 4'd11;
         4'd2, 4'd3, 4'd5, 4'd6: return op[3:0] == 4'd0;
         4'd4:                   return op[3:0] <= 4'd5;
         default:                return 1'b0;
      endcase
   endfunction

   // Branch conditions look at the flags latched by the last ALU instruction,
   // not the live ALU outputs.
   function automatic logic br_taken(input logic [3:0] fn, input logic [2:0] fl);
      case (fn)
         4'd0:    return 1'b1;
         4'd1:    return fl[0];
         4'd2:    return !fl[0];
         4'd3:    return fl[1];
         4'd4:    return !fl[1];
         4'd5:    return fl[2];
         default: return 1'b0;
      endcase
   endfunction

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      flags_d     = flags_q;
      timer_d     = '0;          // timer only survives while still waiting
      cnt_d       = cnt_q;
      halted_d    = halted_q;
      illegal_d   = illegal_q;
      bus_error_d = bus_error_q;
      retire      = 1'b0;
      imem_req    = 1'b0;
      ir_load     = 1'b0;
      alu_op      = 4'd0;
      alu_src_imm = 1'b0;
      dmem_req    = 1'b0;
      dmem_we     = 1'b0;
      reg_write   = 1'b0;
      wb_sel_mem  = 1'b0;
      pc_write    = 1'b0;
      pc_src      = 2'd0;

      case (state_q)
         S_IDLE: begin
            if (start) state_d = S_FETCH;
         end
         S_FETCH: begin
            imem_req = 1'b1;
            if (imem_valid) begin
               ir_load = 1'b1;
               state_d = S_DECODE;
            end else if (timer_q == TW'(TIMEOUT - 1)) begin
               state_d     = S_ERROR;
               bus_error_d = 1'b1;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         S_DECODE: begin
            op_d = opcode;
            if (!is_legal(opcode)) begin
               state_d   = S_ERROR;
               illegal_d = 1'b1;
            end else if (opcode[7:4] == 4'd6) begin
               state_d  = S_HALT;
               halted_d = 1'b1;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            case (op_q[7:4])
               4'd0, 4'd1: begin
                  alu_op      = op_q[3:0];
                  alu_src_imm = op_q[4];
                  flags_d     = {alu_carry, alu_sign, alu_zero};
                  state_d     = S_WB;
               end
               4'd2, 4'd3: begin
                  // address = base + immediate
                  alu_src_imm = 1'b1;
                  state_d     = S_MEM;
               end
               4'd4: begin
                  pc_write = 1'b1;
                  pc_src   = br_taken(op_q[3:0], flags_q) ? 2'd1 : 2'd0;
                  retire   = 1'b1;
                  state_d  = S_FETCH;
               end
               4'd5: begin
                  pc_write = 1'b1;
                  pc_src   = 2'd2;
                  retire   = 1'b1;
                  state_d  = S_FETCH;
               end
               default: begin
                  // op_q was legality-checked in DECODE; this is unreachable
                  state_d   = S_ERROR;
                  illegal_d = 1'b1;
               end
            endcase
         end
         S_MEM: begin
            dmem_req = 1'b1;
            dmem_we  = (op_q[7:4] == 4'd3);
            if (dmem_ready) begin
               if (op_q[7:4] == 4'd3) begin
                  pc_write = 1'b1;
                  retire   = 1'b1;
                  state_d  = S_FETCH;
               end else begin
                  state_d = S_WB;
               end
            end else if (timer_q == TW'(TIMEOUT - 1)) begin
               state_d     = S_ERROR;
               bus_error_d = 1'b1;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         S_WB: begin
            reg_write  = 1'b1;
            wb_sel_mem = (op_q[7:4] == 4'd2);
            pc_write   = 1'b1;
            retire     = 1'b1;
            state_d    = S_FETCH;
         end
         default: ;  // HALT / ERROR hold until reset
      endcase

      if (retire) cnt_d = cnt_q + COUNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         op_q        <= '0;
         flags_q     <= '0;
         timer_q     <= '0;
         cnt_q       <= '0;
         halted_q    <= 1'b0;
         illegal_q   <= 1'b0;
         bus_error_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         flags_q     <= flags_d;
         timer_q     <= timer_d;
         cnt_q       <= cnt_d;
         halted_q    <= halted_d;
         illegal_q   <= illegal_d;
         bus_error_q <= bus_error_d;
      end
   end

   assign halted      = halted_q;
   assign illegal     = illegal_q;
   assign bus_error   = bus_error_q;
   assign state       = state_q;
   assign instr_count = cnt_q;

endmodule
